// File: rtl/conv1_kernel_fetch_ctrl_if.sv
// ROM read ports and weight-pair output stream of the conv1 kernel fetch sequencer.
// master: the sequencer; slave: the ROM/MAC-array side.
interface conv1_kernel_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0] rom_addr_a;
  logic [ADDR_W-1:0] rom_addr_b;
  logic [DATA_W-1:0] rom_q_a;
  logic [DATA_W-1:0] rom_q_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data_a;
  logic [DATA_W-1:0] out_data_b;
  logic              out_b_valid;
  logic              out_last;

  modport master (
    output rom_addr_a, rom_addr_b, out_valid, out_data_a, out_data_b, out_b_valid, out_last,
    input  rom_q_a, rom_q_b, out_ready
  );

  modport slave (
    input  rom_addr_a, rom_addr_b, out_valid, out_data_a, out_data_b, out_b_valid, out_last,
    output rom_q_a, rom_q_b, out_ready
  );
endinterface

// File: rtl/conv1_kernel_fetch_ctrl.sv
// Conv1 kernel ROM fetch sequencer: two weights per beat, 2-entry skid buffer on the stream.
// Define CONV1_FETCH_STALL_CNT_EN to add the stall_cycles backpressure counter.
module conv1_kernel_fetch_ctrl #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 7
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
`ifdef CONV1_FETCH_STALL_CNT_EN
  output logic [15:0]       stall_cycles,
`endif
  conv1_kernel_fetch_ctrl_if.master bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              bv;
    logic              last;
  } beat_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d, issue_addr;
  logic [ADDR_W-1:0] pairs_q, pairs_d;
  logic              odd_q, odd_d, odd_now;
  logic [ADDR_W-1:0] rom_addr_a_q, rom_addr_b_q;
  logic              addr_vld_q, addr_bv_q, addr_last_q;
  logic              dat_vld_q, dat_bv_q, dat_last_q;
  beat_t             buf_q [2];
  beat_t             buf_d [2];
  logic [1:0]        count_q, count_d, wr_idx;

  logic [LEN_W-1:0]  len_c;
  logic [LEN_W:0]    len_p1;
  logic [ADDR_W-1:0] total;
  logic              issue, issue_last, issue_bv;
  logic [2:0]        occ;
  logic              credit_ok, pop, out_valid;
  beat_t             incoming, head;

  assign len_c  = (length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : length;
  assign len_p1 = {1'b0, len_c} + (LEN_W + 1)'(1);
  assign total  = len_p1[ADDR_W:1];

  // Pairs on the ROM bus or ROM output count against the buffer; a pop frees a slot now.
  assign occ       = 3'(count_q) + 3'(addr_vld_q) + 3'(dat_vld_q);
  assign credit_ok = occ < (3'd2 + 3'(pop));

  assign incoming  = {bus.rom_q_a, bus.rom_q_b, dat_bv_q, dat_last_q};
  assign head      = (count_q != 2'd0) ? buf_q[0] : incoming;
  assign out_valid = (count_q != 2'd0) || dat_vld_q;
  assign pop       = out_valid && bus.out_ready;

  always_comb begin
    state_d    = state_q;
    pairs_d    = pairs_q;
    odd_d      = odd_q;
    odd_now    = odd_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_addr = next_addr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          odd_d = len_c[0];
          if (len_c == '0) begin
            state_d = StDone;
          end else begin
            // First pair leaves on the accepting edge so data reaches the stream 2 cycles later.
            issue      = 1'b1;
            issue_addr = base_addr;
            odd_now    = len_c[0];
            issue_last = (total == ADDR_W'(1));
            pairs_d    = total - ADDR_W'(1);
            state_d    = StFetch;
          end
        end
      end
      StFetch: begin
        if (pairs_q == '0) begin
          state_d = StDrain;
        end else if (credit_ok) begin
          issue      = 1'b1;
          issue_last = (pairs_q == ADDR_W'(1));
          pairs_d    = pairs_q - ADDR_W'(1);
          if (issue_last) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && head.last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign issue_bv    = !(issue_last && odd_now);
  assign next_addr_d = issue ? issue_addr + ADDR_W'(2) : next_addr_q;
  assign wr_idx      = count_q - 2'(pop);

  // FIFO order: a pop shifts the head out before the arriving pair lands behind what remains.
  always_comb begin
    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    if (pop && (count_q != 2'd0)) buf_d[0] = buf_q[1];
    if (dat_vld_q && !(pop && (count_q == 2'd0))) buf_d[wr_idx[0]] = incoming;
    count_d = count_q + 2'(dat_vld_q) - 2'(pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      next_addr_q  <= '0;
      pairs_q      <= '0;
      odd_q        <= 1'b0;
      rom_addr_a_q <= '0;
      rom_addr_b_q <= '0;
      addr_vld_q   <= 1'b0;
      addr_bv_q    <= 1'b0;
      addr_last_q  <= 1'b0;
      dat_vld_q    <= 1'b0;
      dat_bv_q     <= 1'b0;
      dat_last_q   <= 1'b0;
      buf_q[0]     <= '0;
      buf_q[1]     <= '0;
      count_q      <= '0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      pairs_q     <= pairs_d;
      odd_q       <= odd_d;
      if (issue) begin
        rom_addr_a_q <= issue_addr;
        rom_addr_b_q <= issue_addr + ADDR_W'(1);
      end
      addr_vld_q  <= issue;
      addr_bv_q   <= issue_bv;
      addr_last_q <= issue_last;
      dat_vld_q   <= addr_vld_q;
      dat_bv_q    <= addr_bv_q;
      dat_last_q  <= addr_last_q;
      buf_q[0]    <= buf_d[0];
      buf_q[1]    <= buf_d[1];
      count_q     <= count_d;
    end
  end

`ifdef CONV1_FETCH_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      stall_q <= '0;
    end else if (out_valid && !bus.out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

  assign bus.rom_addr_a  = rom_addr_a_q;
  assign bus.rom_addr_b  = rom_addr_b_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_data_a  = head.a;
  assign bus.out_data_b  = head.b;
  assign bus.out_b_valid = out_valid && head.bv;
  assign bus.out_last    = out_valid && head.last;
  assign busy            = (state_q != StIdle);
  assign done            = (state_q == StDone);
endmodule

// File: tb/tb_conv1_kernel_fetch_ctrl.sv
// Directed bench for conv1_kernel_fetch_ctrl; ROM word at address i holds 16'hA000 + i.
module tb_conv1_kernel_fetch_ctrl;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [5:0]  base_addr;
  logic [6:0]  length;
  logic        busy;
  logic        done;
`ifdef CONV1_FETCH_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  conv1_kernel_fetch_ctrl_if #(.ADDR_W(6), .DATA_W(16)) bus ();

  conv1_kernel_fetch_ctrl #(.ADDR_W(6), .DATA_W(16), .LEN_W(7)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
`ifdef CONV1_FETCH_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .bus         (bus)
  );

  always #5 clock = ~clock;

  logic [15:0] rom [64];
  initial for (int i = 0; i < 64; i++) rom[i] = 16'hA000 + 16'(i);

  always @(posedge clock) begin
    bus.rom_q_a <= rom[bus.rom_addr_a];
    bus.rom_q_b <= rom[bus.rom_addr_b];
  end

  int tests = 0;
  int fails = 0;

  logic [15:0] q_a [$];
  logic [15:0] q_b [$];
  logic        q_bv [$];
  logic        q_last [$];
  int first_valid, last_hs, done_cyc, stalls, unstable;

  // Issues one command and records every handshaken beat until done or the cycle budget.
  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1 repeated.
  task automatic run_cmd(input logic [5:0] b, input logic [6:0] l, input int mode,
                         input int restart_cyc, input int budget);
    logic [15:0] sa, sb;
    logic        sbv, slast, stalled;
    q_a.delete(); q_b.delete(); q_bv.delete(); q_last.delete();
    first_valid = -1; last_hs = -1; done_cyc = -1; stalls = 0; unstable = 0;
    stalled = 1'b0; sa = '0; sb = '0; sbv = 1'b0; slast = 1'b0;
    @(negedge clock);
    start = 1'b1; base_addr = b; length = l;
    for (int cyc = 1; cyc <= budget && done_cyc < 0; cyc++) begin
      @(negedge clock);
      start = (cyc == restart_cyc);
      if (start) begin
        base_addr = 6'd10;
        length    = 7'd4;
      end
      bus.out_ready = (mode == 0) || ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
      if (stalled && (bus.out_valid !== 1'b1 || bus.out_data_a !== sa || bus.out_data_b !== sb ||
                      bus.out_b_valid !== sbv || bus.out_last !== slast)) unstable++;
      stalled = 1'b0;
      if (done === 1'b1) done_cyc = cyc;
      if (bus.out_valid === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        if (bus.out_ready) begin
          q_a.push_back(bus.out_data_a);
          q_b.push_back(bus.out_data_b);
          q_bv.push_back(bus.out_b_valid);
          q_last.push_back(bus.out_last);
          last_hs = cyc;
        end else begin
          stalls++;
          stalled = 1'b1;
          sa = bus.out_data_a; sb = bus.out_data_b; sbv = bus.out_b_valid; slast = bus.out_last;
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    @(negedge clock);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    tests++; if (bus.out_last !== 1'b0 || bus.out_b_valid !== 1'b0) begin
      fails++; $display("FAIL reset_flags: got last=%b bv=%b want 0 0", bus.out_last, bus.out_b_valid);
    end
    tests++; if (bus.rom_addr_a !== 6'd0 || bus.rom_addr_b !== 6'd0) begin
      fails++; $display("FAIL reset_addr: got %0d/%0d want 0/0", bus.rom_addr_a, bus.rom_addr_b);
    end
`ifdef CONV1_FETCH_STALL_CNT_EN
    tests++; if (stall_cycles !== 16'd0) begin fails++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
`endif
    reset_n = 1'b1;
  endtask

  task automatic test_even_len();
    @(negedge clock);
    start = 1'b1; base_addr = 6'd0; length = 7'd4; bus.out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    tests++; if (bus.rom_addr_a !== 6'd0 || bus.rom_addr_b !== 6'd1) begin
      fails++; $display("FAIL even_addr_c1: got %0d/%0d want 0/1", bus.rom_addr_a, bus.rom_addr_b);
    end
    tests++; if (bus.out_valid !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL even_c1: got valid=%b busy=%b want 0 1", bus.out_valid, busy);
    end
    @(negedge clock);
    tests++; if ({bus.out_valid, bus.out_data_a, bus.out_data_b, bus.out_b_valid, bus.out_last} !==
                 {1'b1, 16'hA000, 16'hA001, 1'b1, 1'b0}) begin
      fails++; $display("FAIL even_beat0: got v=%b %h %h bv=%b l=%b want 1 a000 a001 1 0",
                        bus.out_valid, bus.out_data_a, bus.out_data_b, bus.out_b_valid, bus.out_last);
    end
    @(negedge clock);
    tests++; if ({bus.out_valid, bus.out_data_a, bus.out_data_b, bus.out_b_valid, bus.out_last} !==
                 {1'b1, 16'hA002, 16'hA003, 1'b1, 1'b1}) begin
      fails++; $display("FAIL even_beat1: got v=%b %h %h bv=%b l=%b want 1 a002 a003 1 1",
                        bus.out_valid, bus.out_data_a, bus.out_data_b, bus.out_b_valid, bus.out_last);
    end
    @(negedge clock);
    tests++; if (done !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL even_done: got done=%b valid=%b want 1 0", done, bus.out_valid);
    end
    @(negedge clock);
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL even_idle: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_wrap_odd();
    logic [15:0] ea [3];
    logic [15:0] eb [3];
    logic        el [3];
    logic        ebv [3];
    ea = '{16'hA03E, 16'hA000, 16'hA002};
    eb = '{16'hA03F, 16'hA001, 16'h0000};
    el = '{1'b0, 1'b0, 1'b1};
    ebv = '{1'b1, 1'b1, 1'b0};
    run_cmd(6'd62, 7'd5, 0, 0, 20);
    tests++; if (q_a.size() != 3) begin fails++; $display("FAIL wrap_count: got %0d want 3", q_a.size()); end
    for (int k = 0; k < 3 && k < q_a.size(); k++) begin
      tests++;
      if (q_a[k] !== ea[k] || (k < 2 && q_b[k] !== eb[k]) || q_last[k] !== el[k] || q_bv[k] !== ebv[k]) begin
        fails++; $display("FAIL wrap_beat%0d: got %h %h bv=%b l=%b want %h %h bv=%b l=%b", k,
                          q_a[k], q_b[k], q_bv[k], q_last[k], ea[k], eb[k], ebv[k], el[k]);
      end
    end
    tests++; if (done_cyc != 5) begin fails++; $display("FAIL wrap_done_cyc: got %0d want 5", done_cyc); end
  endtask

  task automatic test_full_len_backpressure();
    int bad;
    run_cmd(6'd0, 7'd64, 1, 0, 400);
    tests++; if (q_a.size() != 32) begin fails++; $display("FAIL bp_count: got %0d want 32", q_a.size()); end
    bad = 0;
    for (int k = 0; k < 32 && k < q_a.size(); k++) begin
      tests++;
      if (q_a[k] !== 16'hA000 + 16'(2 * k) || q_b[k] !== 16'hA001 + 16'(2 * k) ||
          q_bv[k] !== 1'b1 || q_last[k] !== (k == 31)) begin
        fails++; $display("FAIL bp_beat%0d: got %h %h bv=%b l=%b want %h %h 1 %0d", k, q_a[k], q_b[k],
                          q_bv[k], q_last[k], 16'hA000 + 16'(2 * k), 16'hA001 + 16'(2 * k), k == 31);
      end
    end
    tests++; if (unstable != 0) begin fails++; $display("FAIL bp_stable: got %0d unstable stalls want 0", unstable); end
    tests++; if (done_cyc < 0 || done_cyc != last_hs + 1) begin
      fails++; $display("FAIL bp_done: got done at %0d, last handshake %0d", done_cyc, last_hs);
    end
`ifdef CONV1_FETCH_STALL_CNT_EN
    tests++; if (stall_cycles !== 16'(stalls)) begin
      fails++; $display("FAIL bp_stall_cnt: got %0d want %0d", stall_cycles, stalls);
    end
    @(negedge clock);
    tests++; if (stall_cycles !== 16'(stalls)) begin
      fails++; $display("FAIL bp_stall_hold: got %0d want %0d", stall_cycles, stalls);
    end
`endif
  endtask

  task automatic test_zero_len();
    run_cmd(6'd5, 7'd0, 0, 0, 10);
    tests++; if (done_cyc != 1 || first_valid != -1) begin
      fails++; $display("FAIL zero_done: got done_cyc=%0d first_valid=%0d want 1 -1", done_cyc, first_valid);
    end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL zero_busy: got %b want 1", busy); end
`ifdef CONV1_FETCH_STALL_CNT_EN
    tests++; if (stall_cycles !== 16'd0) begin fails++; $display("FAIL zero_stall_clear: got %0d want 0", stall_cycles); end
`endif
    @(negedge clock);
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL zero_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_clamp();
    run_cmd(6'd0, 7'd127, 0, 0, 60);
    tests++; if (q_a.size() != 32) begin fails++; $display("FAIL clamp_count: got %0d want 32", q_a.size()); end
    tests++; if (q_a.size() == 32 && (q_a[31] !== 16'hA03E || q_b[31] !== 16'hA03F || q_last[31] !== 1'b1)) begin
      fails++; $display("FAIL clamp_last: got %h %h l=%b want a03e a03f 1", q_a[31], q_b[31], q_last[31]);
    end
    tests++; if (first_valid != 2 || done_cyc != 34) begin
      fails++; $display("FAIL clamp_timing: got first=%0d done=%0d want 2 34", first_valid, done_cyc);
    end
  endtask

  task automatic test_back_to_back();
    run_cmd(6'd20, 7'd8, 0, 2, 20);
    tests++; if (q_a.size() != 4) begin fails++; $display("FAIL restart_count: got %0d want 4", q_a.size()); end
    tests++; if (q_a.size() == 4 && (q_a[0] !== 16'hA014 || q_a[3] !== 16'hA01A || q_b[3] !== 16'hA01B)) begin
      fails++; $display("FAIL restart_data: got %h %h %h want a014 a01a a01b", q_a[0], q_a[3], q_b[3]);
    end
    tests++; if (done_cyc != 6) begin fails++; $display("FAIL restart_done: got %0d want 6", done_cyc); end
    run_cmd(6'd10, 7'd4, 0, 0, 20);
    tests++; if (q_a.size() != 2 || q_a[0] !== 16'hA00A || q_b[1] !== 16'hA00D || done_cyc != 4) begin
      fails++; $display("FAIL next_cmd: got n=%0d %h %h done=%0d want 2 a00a a00d 4",
                        q_a.size(), q_a[0], q_b[1], done_cyc);
    end
  endtask

  task automatic test_reset_drain();
    int seen;
    @(negedge clock);
    start = 1'b1; base_addr = 6'd0; length = 7'd4; bus.out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    tests++; if (bus.out_valid !== 1'b1 || bus.out_data_a !== 16'hA002 || bus.out_last !== 1'b1) begin
      fails++; $display("FAIL drain_pre: got v=%b %h l=%b want 1 a002 1", bus.out_valid, bus.out_data_a, bus.out_last);
    end
    reset_n = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL drain_reset: got v=%b busy=%b done=%b want 0 0 0", bus.out_valid, busy, done);
    end
    @(negedge clock);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL drain_no_done: got %0d active cycles want 0", seen); end
    run_cmd(6'd8, 7'd2, 0, 0, 20);
    tests++; if (q_a.size() != 1 || q_a[0] !== 16'hA008 || q_b[0] !== 16'hA009 || q_last[0] !== 1'b1) begin
      fails++; $display("FAIL drain_recover: got n=%0d %h %h want 1 a008 a009", q_a.size(), q_a[0], q_b[0]);
    end
    tests++; if (first_valid != 2 || done_cyc != 3) begin
      fails++; $display("FAIL drain_recover_timing: got first=%0d done=%0d want 2 3", first_valid, done_cyc);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; bus.out_ready = 1'b1;
    test_reset();
    test_even_len();
    test_wrap_odd();
    test_full_len_backpressure();
    test_zero_len();
    test_clamp();
    test_back_to_back();
    test_reset_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
